// File: rtl/fsm_cu_gen.sv
// rtl/fsm_cu_gen.sv - Moore control unit sequencing operand load, execute, writeback and display
module fsm_cu_gen #(
  parameter int                 AW         = 2,
  parameter int                 OPW        = 2,
  parameter logic [AW-1:0]      ADDR_A     = AW'(1),
  parameter logic [AW-1:0]      ADDR_B     = AW'(2),
  parameter logic [AW-1:0]      ADDR_R     = AW'(3),
  parameter logic [OPW-1:0]     DISP_C     = OPW'(2),
  parameter logic [2**OPW-1:0]  MULTI_MASK = '0,
  parameter int                 TMO        = 15
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Go,
  input  logic [OPW-1:0] Op,
  input  logic           AluAck,
  output logic [1:0]     Sel1,
  output logic [AW-1:0]  WA,
  output logic           WE,
  output logic [AW-1:0]  RAA,
  output logic           REA,
  output logic [AW-1:0]  RAB,
  output logic           REB,
  output logic [OPW-1:0] C,
  output logic           Sel2,
  output logic           Done,
  output logic           Start,
  output logic           Busy,
  output logic           Err,
  output logic [3:0]     CS
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOADA = 4'd1,
    S_LOADB = 4'd2,
    S_EXEC  = 4'd3,
    S_DISP  = 4'd4,
    S_WAIT  = 4'd5,
    S_STALL = 4'd6,
    S_WRBK  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           multi;

  // The latched opcode alone decides whether the ALU needs the stall/handshake path
  assign multi = MULTI_MASK[op_q];

  // State, latched opcode and stall timeout counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; opcode is captured only when a sequence is accepted
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Go) begin
          state_d = S_LOADA;
          op_d    = Op;
        end
      end
      S_LOADA: state_d = S_LOADB;
      S_LOADB: state_d = S_EXEC;
      S_EXEC: begin
        if (multi) begin
          state_d = S_STALL;
          cnt_d   = '0;
        end else begin
          state_d = S_DISP;
        end
      end
      S_STALL: begin
        cnt_d = cnt_q + 1'b1;
        // An acknowledge arriving on the last allowed cycle still completes normally
        if (AluAck) begin
          state_d = S_WRBK;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WRBK:  state_d = S_DISP;
      S_DISP:  state_d = S_WAIT;
      S_WAIT:  state_d = Go ? S_WAIT : S_IDLE;
      S_ERR:   state_d = Go ? S_ERR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from current state and latched opcode
  always_comb begin
    Sel1  = 2'b00;
    WA    = '0;
    WE    = 1'b0;
    RAA   = '0;
    REA   = 1'b0;
    RAB   = '0;
    REB   = 1'b0;
    C     = '0;
    Sel2  = 1'b0;
    Done  = 1'b0;
    Start = 1'b0;
    Busy  = 1'b0;
    Err   = 1'b0;
    CS    = state_q;
    case (state_q)
      S_LOADA: begin
        Sel1 = 2'b11;
        WA   = ADDR_A;
        WE   = 1'b1;
        Busy = 1'b1;
      end
      S_LOADB: begin
        Sel1 = 2'b10;
        WA   = ADDR_B;
        WE   = 1'b1;
        Busy = 1'b1;
      end
      S_EXEC, S_STALL, S_WRBK: begin
        WA    = ADDR_R;
        RAA   = ADDR_A;
        REA   = 1'b1;
        RAB   = ADDR_B;
        REB   = 1'b1;
        C     = op_q;
        Busy  = 1'b1;
        // Single-cycle results are written straight from EXEC; multi-cycle ones wait for WRBK
        WE    = (state_q == S_EXEC) ? ~multi : (state_q == S_WRBK);
        Start = (state_q == S_EXEC) && multi;
      end
      S_DISP: begin
        Sel1 = 2'b01;
        RAA  = ADDR_R;
        REA  = 1'b1;
        RAB  = ADDR_R;
        REB  = 1'b1;
        C    = DISP_C;
        Sel2 = 1'b1;
        Done = 1'b1;
        Busy = 1'b1;
      end
      S_ERR: begin
        Sel1 = 2'b01;
        Err  = 1'b1;
      end
      default: begin
        Sel1 = 2'b01;
        CS   = state_q;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_cu_gen.sv
// tb/tb_fsm_cu_gen.sv - self-checking bench for fsm_cu_gen with default and multi-cycle instances
module tb_fsm_cu_gen;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      go;
  logic [1:0][1:0] op_i;
  logic [1:0]      ack;
  logic [1:0][1:0] sel1, wa, raa, rab, c;
  logic [1:0]      we, rea, reb, sel2, done, start, busy, err;
  logic [1:0][3:0] cs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance 0: all defaults (every opcode single-cycle, TMO=15)
  fsm_cu_gen u_def (
    .CLK(clk), .RST(rst), .Go(go[0]), .Op(op_i[0]), .AluAck(ack[0]),
    .Sel1(sel1[0]), .WA(wa[0]), .WE(we[0]), .RAA(raa[0]), .REA(rea[0]),
    .RAB(rab[0]), .REB(reb[0]), .C(c[0]), .Sel2(sel2[0]), .Done(done[0]),
    .Start(start[0]), .Busy(busy[0]), .Err(err[0]), .CS(cs[0])
  );

  // Instance 1: opcode 2 multi-cycle, TMO=4
  fsm_cu_gen #(.MULTI_MASK(4'b0100), .TMO(4)) u_mc (
    .CLK(clk), .RST(rst), .Go(go[1]), .Op(op_i[1]), .AluAck(ack[1]),
    .Sel1(sel1[1]), .WA(wa[1]), .WE(we[1]), .RAA(raa[1]), .REA(rea[1]),
    .RAB(rab[1]), .REB(reb[1]), .C(c[1]), .Sel2(sel2[1]), .Done(done[1]),
    .Start(start[1]), .Busy(busy[1]), .Err(err[1]), .CS(cs[1])
  );

  // Control word {Sel1,WA,WE,RAA,REA,RAB,REB,C,Sel2,Done,Start,Busy,Err} from the state tables
  function automatic logic [17:0] exp_word(int st, logic [1:0] op, bit mc);
    logic [1:0] s1 = 2'd0, a_w = 2'd0, a_a = 2'd0, a_b = 2'd0, cc = 2'd0;
    logic w = 1'b0, ra = 1'b0, rb = 1'b0, s2 = 1'b0, dn = 1'b0, stt = 1'b0, bz, er;
    bz = st inside {1, 2, 3, 4, 6, 7};
    er = (st == 8);
    case (st)
      1: begin s1 = 2'b11; a_w = 2'd1; w = 1'b1; end
      2: begin s1 = 2'b10; a_w = 2'd2; w = 1'b1; end
      3, 6, 7: begin
        a_w = 2'd3; a_a = 2'd1; ra = 1'b1; a_b = 2'd2; rb = 1'b1; cc = op;
        w   = (st == 3) ? !mc : (st == 7);
        stt = (st == 3) && mc;
      end
      4: begin s1 = 2'b01; a_a = 2'd3; ra = 1'b1; a_b = 2'd3; rb = 1'b1; cc = 2'd2; s2 = 1'b1; dn = 1'b1; end
      default: s1 = 2'b01;
    endcase
    return {s1, a_w, w, a_a, ra, a_b, rb, cc, s2, dn, stt, bz, er};
  endfunction

  function automatic logic [17:0] obs_word(int d);
    return {sel1[d], wa[d], we[d], raa[d], rea[d], rab[d], reb[d], c[d],
            sel2[d], done[d], start[d], busy[d], err[d]};
  endfunction

  task automatic chk(string tag, int d, int st, logic [1:0] op, bit mc);
    logic [17:0] ew = exp_word(st, op, mc);
    logic [17:0] ow = obs_word(d);
    n_chk++;
    assert (cs[d] === 4'(st)) else begin
      n_fail++;
      $error("FAIL %s dut%0d CS observed=%0d expected=%0d", tag, d, cs[d], st);
    end
    n_chk++;
    assert (ow === ew) else begin
      n_fail++;
      $error("FAIL %s dut%0d word observed=%b expected=%b (state %0d)", tag, d, ow, ew, st);
    end
  endtask

  // One clock, then check that the instance not under test is still idle
  task automatic step(int d);
    @(posedge clk);
    #1;
    chk("other_idle", 1 - d, 0, 2'd0, 1'b0);
  endtask

  // One full transaction: expected state trace is built from the sequencing rules up front
  task automatic run_txn(int d, logic [1:0] op, int ack_n, int hold);
    bit mc;
    int tmo, nst, sidx, wst;
    int q[$];
    mc  = (d == 1) && (op == 2'd2);
    tmo = (d == 1) ? 4 : 15;
    q   = {1, 2, 3};
    if (!mc) begin
      q.push_back(4);
    end else begin
      nst = (ack_n < tmo) ? ack_n + 1 : tmo;
      repeat (nst) q.push_back(6);
      if (ack_n < tmo) begin
        q.push_back(7);
        q.push_back(4);
      end else begin
        q.push_back(8);
      end
    end
    go[d]   = 1'b1;
    op_i[d] = op;
    ack[d]  = 1'b0;
    sidx    = 0;
    foreach (q[i]) begin
      step(d);
      chk("seq", d, q[i], op, mc);
      // Mid-sequence Go/Op noise must be ignored
      go[d]   = 1'($urandom_range(0, 1));
      op_i[d] = 2'($urandom);
      if (q[i] == 6) begin
        ack[d] = (sidx == ack_n);
        sidx++;
      end else begin
        ack[d] = (q[i] inside {1, 2, 3}) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    ack[d] = 1'b0;
    if (q[$] == 4) begin
      step(d);
      chk("wait", d, 5, op, mc);
    end
    wst = (q[$] == 4) ? 5 : 8;
    repeat (hold) begin
      go[d] = 1'b1;
      step(d);
      chk("hold", d, wst, op, mc);
    end
    go[d] = 1'b0;
    step(d);
    chk("to_idle", d, 0, op, mc);
    step(d);
    chk("stay_idle", d, 0, op, mc);
  endtask

  initial begin
    rst  = 1'b1;
    go   = '0;
    op_i = '0;
    ack  = '0;
    #1;
    chk("reset", 0, 0, 2'd0, 1'b0);
    chk("reset", 1, 0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_edge", 0, 0, 2'd0, 1'b0);
    rst = 1'b0;

    for (int o = 0; o < 4; o++) run_txn(0, 2'(o), 0, o % 3);
    run_txn(1, 2'd2, 2, 0);
    run_txn(1, 2'd2, 99, 2);
    run_txn(1, 2'd2, 3, 1);
    run_txn(1, 2'd2, 0, 0);
    for (int o = 0; o < 4; o++) if (o != 2) run_txn(1, 2'(o), 0, 1);
    for (int k = 0; k < 24; k++)
      run_txn(int'($urandom_range(0, 1)), 2'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));

    // Asynchronous reset while in LOADB
    go[0] = 1'b1; op_i[0] = 2'd1;
    step(0); chk("pre_rst", 0, 1, 2'd1, 1'b0);
    step(0); chk("pre_rst", 0, 2, 2'd1, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst_loadb", 0, 0, 2'd0, 1'b0);
    go[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Asynchronous reset while in STALL
    go[1] = 1'b1; op_i[1] = 2'd2;
    repeat (4) step(1);
    chk("pre_rst", 1, 6, 2'd2, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_rst_stall", 1, 0, 2'd0, 1'b0);
    go[1] = 1'b0;
    @(posedge clk); #1;

    // Go already high at reset release starts on the next edge
    go[0] = 1'b1; op_i[0] = 2'd3;
    #2 rst = 1'b0;
    step(0);
    chk("go_after_rst", 0, 1, 2'd3, 1'b0);
    go[0] = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_loada", 0, 0, 2'd0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    step(0);
    chk("final_idle", 0, 0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_cu_gen.md
FSM_CU_GEN -- requirements
Module: fsm_cu_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AW, 2, register-file address width.
- OPW, 2, opcode width.
- ADDR_A, 1, operand A register.
- ADDR_B, 2, operand B register.
- ADDR_R, 3, result register.
- DISP_C, 2, ALU code driven in DISP.
- MULTI_MASK, 0 (width 2**OPW), bit k=1 marks opcode k multi-cycle.
- TMO, 15, max STALL cycles (>=1).
REQ-002 Ports (name direction width meaning):
- CLK in 1 clock, rising edge.
- RST in 1 reset.
- Go in 1 start request.
- Op in OPW opcode.
- AluAck in 1 multi-cycle result ready.
- Sel1 out 2 input-mux select.
- WA out AW write address.
- WE out 1 write enable.
- RAA out AW read address A.
- REA out 1 read enable A.
- RAB out AW read address B.
- REB out 1 read enable B.
- C out OPW ALU code.
- Sel2 out 1 output-mux select.
- Done out 1 result valid.
- Start out 1 multi-cycle ALU start pulse.
- Busy out 1 sequence in progress.
- Err out 1 timeout flag.
- CS out 4 current state.
REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 States/CS: IDLE=0, LOADA=1, LOADB=2, EXEC=3, DISP=4, WAIT=5, STALL=6, WRBK=7, ERR=8; all outputs Moore-decoded from state and latched opcode only.
REQ-005 Transitions: IDLE->LOADA on Go=1, else stay; LOADA->LOADB->EXEC unconditional.
REQ-006 EXEC->STALL if MULTI_MASK[OpReg]=1, else EXEC->DISP.
REQ-007 STALL->WRBK on AluAck=1; STALL->ERR after TMO STALL cycles without AluAck; AluAck on the timeout cycle wins (->WRBK).
REQ-008 WRBK->DISP; DISP->WAIT; WAIT and ERR stay while Go=1, ->IDLE when Go=0.
REQ-009 OpReg captures Op only on the IDLE->LOADA edge; Op and Go changes mid-sequence are ignored.
REQ-010 Timeout counter clears on EXEC->STALL, increments once per STALL cycle, width ceil(log2(TMO+1)).
REQ-011 IDLE/WAIT/ERR word: Sel1=01, all other control fields 0.
REQ-012 LOADA: Sel1=11, WA=ADDR_A, WE=1, rest 0; LOADB: Sel1=10, WA=ADDR_B, WE=1, rest 0.
REQ-013 EXEC/STALL/WRBK: Sel1=00, WA=ADDR_R, RAA=ADDR_A, REA=1, RAB=ADDR_B, REB=1, C=OpReg, Sel2=0, Done=0.
REQ-014 WE in EXEC = ~MULTI_MASK[OpReg]; WE=0 in STALL; WE=1 in WRBK.
REQ-015 DISP: Sel1=01, WA=0, WE=0, RAA=RAB=ADDR_R, REA=REB=1, C=DISP_C, Sel2=1, Done=1.
REQ-016 Start=1 only in EXEC with a multi-cycle opcode (exactly one cycle); Busy=1 in states 1-4, 6, 7; Err=1 only in ERR.
REQ-017 Latency Go-accept to Done: 4 edges single-cycle; 6+n edges multi-cycle with AluAck in STALL cycle n (n from 0).

Reset
REQ-018 RST=1 forces IDLE (CS=0), OpReg=0, counter=0, outputs to IDLE word asynchronously, including mid-sequence and from ERR.
REQ-019 After RST release, a Go already high starts a sequence on the next edge.

Verification
REQ-020 Defaults, Op=0..3, Go=1: CS 1,2,3,4,5; EXEC C=Op, WE=1; DISP control word 01_00_0_11_1_11_1_10_1_1.
REQ-021 MULTI_MASK=4'b0100, Op=2, AluAck on 3rd STALL cycle: Start one cycle, EXEC WE=0, CS 3,6,6,6,7,4, WE=1 only in WRBK.
REQ-022 MULTI_MASK=4'b0100, TMO=4, Op=2, AluAck=0: 4 STALL cycles, then CS=8, Err=1, Done never 1; Go=0 -> IDLE.
REQ-023 Go held high through DISP: FSM stays WAIT (CS=5); no restart until Go low then high.
REQ-024 Op changed during LOADB: EXEC C holds value sampled at Go edge.
REQ-025 RST pulsed in STALL and in LOADB: CS=0 and IDLE word within the reset pulse, no clock edge needed.
